mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single main-memory request/response port between the instruction cache and the data cache of the 3-stage RISC-V core. Arbitrates one transaction at a time and holds the grant until a read response returns. Routes each response to its owner. Uses fixed data-cache priority, with a streak counter that prevents instruction-cache starvation. Sits between both caches and the memory model/AXI bridge.

Parameters:
ADDR_WIDTH, 28, memory word-address width (16-byte lines)
DATA_WIDTH, 128, memory data width
MASK_WIDTH, DATA_WIDTH/8, byte-write mask width
DC_STREAK_MAX, 4, consecutive contested dcache grants before icache is forced

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
ic_req_valid  in  1  icache request valid (read only)
ic_req_ready  out  1  icache request accepted this cycle
ic_req_addr  in  ADDR_WIDTH  icache read address
ic_resp_valid  out  1  icache read data valid (1-cycle pulse)
ic_resp_data  out  DATA_WIDTH  icache read data
dc_req_valid  in  1  dcache request valid
dc_req_ready  out  1  dcache request accepted this cycle
dc_req_rw  in  1  0=read, 1=write
dc_req_addr  in  ADDR_WIDTH  dcache address
dc_req_data  in  DATA_WIDTH  dcache write data
dc_req_mask  in  MASK_WIDTH  dcache byte-write mask
dc_resp_valid  out  1  dcache read data valid (1-cycle pulse)
dc_resp_data  out  DATA_WIDTH  dcache read data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_rw  out  1  0=read, 1=write
mem_req_addr  out  ADDR_WIDTH  memory address
mem_req_data  out  DATA_WIDTH  memory write data
mem_req_mask  out  MASK_WIDTH  memory byte mask (all ones for reads is not required; driven 0 on reads)
mem_resp_valid  in  1  memory read data valid
mem_resp_data  in  DATA_WIDTH  memory read data
protocol_err  out  1  sticky: unexpected mem_resp_valid seen

Behaviour:
- Reset (rst sampled high at a clk edge): state=IDLE, owner=none, streak=0, protocol_err=0; all valid/ready outputs 0. A reset mid-transaction abandons the transaction; no response is forwarded.
- Requesters hold valid and payload stable until their req_ready. mem_req_* payload is a combinational mux of the owner's inputs, not registered.
- IDLE: samples ic_req_valid/dc_req_valid. Picks an owner and registers it; the next state is REQ. One-cycle arbitration latency; mem_req_valid never rises in the same cycle a request first appears.
- Pick rule: only one requester valid → that one. Both valid → dcache, unless streak==DC_STREAK_MAX, in which case icache wins.
- Streak: a dcache grant with ic_req_valid high increments streak, saturating at DC_STREAK_MAX. An icache grant, or a dcache grant with icache idle, clears streak to 0.
- REQ: mem_req_valid=1 with the owner's payload; icache is forced to rw=0 and mask=0. When mem_req_ready is high, the owner's req_ready=1 for that cycle only.
  - Write accepted → IDLE.
  - Read accepted → WAIT_RESP.
- WAIT_RESP: mem_req_valid=0. On mem_resp_valid, the owner's resp_valid=1 in the same cycle (combinational pass-through), and resp_data=mem_resp_data. Next state is IDLE.
  - Earliest response is the cycle after acceptance.
  - A response is not forwarded in the same cycle as acceptance.
- Both resp_data outputs always carry mem_resp_data; only the owner's resp_valid asserts.
- mem_resp_valid in IDLE or REQ → ignored, and protocol_err is set (cleared only by rst).
- Back-to-back: IDLE→REQ→WAIT_RESP→IDLE. Minimum read turnaround is 3 cycles plus memory latency. A write takes 2 cycles when mem_req_ready is already high.
- The non-owner's req_ready and resp_valid stay 0 throughout.

Decomposition:
- Shared package (mem_arb_pkg): state encoding IDLE/REQ/WAIT_RESP, owner encoding OWN_IC/OWN_DC, MEM_READ=0 and MEM_WRITE=1 constants.
- One natural sub-module, mem_arb_pick: combinational priority and streak-override picker. Inputs are the two valid bits and streak==max. Output is the owner.
- The FSM, streak counter, and muxes stay in mem_arbiter.

Test Plan:
- icache read only, addr=0x0000010, mem latency 2 → mem_req_valid in cycle 1, ic_req_ready with mem_req_ready, ic_resp_valid one cycle with 0xDEADBEEF… data; dc_resp_valid stays 0.
- Both request in the same cycle: dc write addr=0x20, mask=0x000F, plus ic read → dcache granted first, mem_req_rw=1, mask=0x000F; icache granted next, and the write produces no response pulse.
- dc_req_valid and ic_req_valid held continuously, DC_STREAK_MAX=4 → grant order DC,DC,DC,DC,IC,DC…; streak returns to 0 after the IC grant.
- mem_req_ready held low 5 cycles in REQ → mem_req_valid and payload stable all 5 cycles; req_ready only in the accept cycle.
- rst asserted during WAIT_RESP, then mem_resp_valid arrives → no resp_valid to either cache; protocol_err=1; next request is arbitrated normally.
- Spurious mem_resp_valid in IDLE after reset → protocol_err=1 next cycle and remains set until rst.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data cache memory-port arbiter.
package mem_arb_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ       = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// Cache-side and memory-side handshake bundle of the arbiter.
interface mem_arb_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
);

  logic                  ic_req_valid;
  logic                  ic_req_ready;
  logic [ADDR_WIDTH-1:0] ic_req_addr;
  logic                  ic_resp_valid;
  logic [DATA_WIDTH-1:0] ic_resp_data;

  logic                  dc_req_valid;
  logic                  dc_req_ready;
  logic                  dc_req_rw;
  logic [ADDR_WIDTH-1:0] dc_req_addr;
  logic [DATA_WIDTH-1:0] dc_req_data;
  logic [MASK_WIDTH-1:0] dc_req_mask;
  logic                  dc_resp_valid;
  logic [DATA_WIDTH-1:0] dc_resp_data;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_rw;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_data;
  logic [MASK_WIDTH-1:0] mem_req_mask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;

  logic                  protocol_err;

  // The arbiter itself.
  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_data,
    input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data, dc_req_mask,
    output dc_req_ready, dc_resp_valid, dc_resp_data,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output protocol_err
  );

  // The surrounding caches and memory.
  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_data,
    output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data, dc_req_mask,
    input  dc_req_ready, dc_resp_valid, dc_resp_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  protocol_err
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Owner picker: dcache has priority unless its contested streak is exhausted.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   ic_valid,
  input  logic   dc_valid,
  input  logic   streak_max,
  output owner_e owner
);

  always_comb begin
    owner = OWN_DC;
    if (ic_valid && (!dc_valid || streak_max)) begin
      owner = OWN_IC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between icache and dcache.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 28,
  parameter int DATA_WIDTH    = 128,
  parameter int MASK_WIDTH    = DATA_WIDTH / 8,
  parameter int DC_STREAK_MAX = 4
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);

  localparam int STREAK_W = $clog2(DC_STREAK_MAX + 1);

  logic [1:0]            state_reg, state_next;
  owner_e                owner_reg, owner_next;
  owner_e                pick_owner;
  logic [STREAK_W-1:0]   streak_reg, streak_next;
  logic                  perr_reg, perr_next;
  logic                  at_max;

  logic                  is_dc;
  logic                  in_req;
  logic                  in_wait;
  logic                  accept;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [MASK_WIDTH-1:0] req_mask;

  assign at_max = (streak_reg == STREAK_W'(DC_STREAK_MAX));

  mem_arb_pick u_pick (
    .ic_valid   (bus.ic_req_valid),
    .dc_valid   (bus.dc_req_valid),
    .streak_max (at_max),
    .owner      (pick_owner)
  );

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    streak_next = streak_reg;
    perr_next   = perr_reg | (bus.mem_resp_valid && (state_reg != WAIT_RESP));
    case (state_reg)
      IDLE: begin
        if (bus.ic_req_valid || bus.dc_req_valid) begin
          owner_next = pick_owner;
          state_next = REQ;
          // Only a dcache win over a waiting icache extends the streak.
          if (pick_owner == OWN_DC && bus.ic_req_valid) begin
            streak_next = at_max ? streak_reg : streak_reg + STREAK_W'(1);
          end else begin
            streak_next = '0;
          end
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_next = (req_rw == MEM_WRITE) ? IDLE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (bus.mem_resp_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      owner_reg  <= OWN_IC;
      streak_reg <= '0;
      perr_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      streak_reg <= streak_next;
      perr_reg   <= perr_next;
    end
  end

  // Handshakes are gated by rst so a transaction being abandoned forwards nothing.
  assign is_dc   = (owner_reg == OWN_DC);
  assign in_req  = (state_reg == REQ) && !rst;
  assign in_wait = (state_reg == WAIT_RESP) && !rst;
  assign accept  = in_req && bus.mem_req_ready;

  assign req_rw   = is_dc ? bus.dc_req_rw : MEM_READ;
  assign req_addr = is_dc ? bus.dc_req_addr : bus.ic_req_addr;
  assign req_data = is_dc ? bus.dc_req_data : '0;

  generate
    for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_mask
      assign req_mask[gi] = is_dc && (bus.dc_req_rw == MEM_WRITE) && bus.dc_req_mask[gi];
    end
  endgenerate

  assign bus.mem_req_valid = in_req;
  assign bus.mem_req_rw    = req_rw;
  assign bus.mem_req_addr  = req_addr;
  assign bus.mem_req_data  = req_data;
  assign bus.mem_req_mask  = req_mask;

  assign bus.ic_req_ready  = accept && !is_dc;
  assign bus.dc_req_ready  = accept && is_dc;

  assign bus.ic_resp_valid = in_wait && bus.mem_resp_valid && !is_dc;
  assign bus.dc_resp_valid = in_wait && bus.mem_resp_valid && is_dc;
  assign bus.ic_resp_data  = bus.mem_resp_data;
  assign bus.dc_resp_data  = bus.mem_resp_data;

  assign bus.protocol_err  = perr_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 28;
  localparam int DW   = 128;
  localparam int MW   = 16;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .DC_STREAK_MAX(SMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // memb is the memory as written through the DUT; refm is what the caches intended.
  logic [DW-1:0] memb [64];
  logic [DW-1:0] refm [64];

  bit            rst_v = 1'b1;
  bit            ic_pend = 1'b0, dc_pend = 1'b0, dc_rw = 1'b0;
  logic [AW-1:0] ic_a = '0, dc_a = '0;
  logic [DW-1:0] dc_d = '0;
  logic [MW-1:0] dc_m = '0;
  bit            auto_ic = 1'b0, auto_dc = 1'b0, rand_req = 1'b0, rand_rdy = 1'b0, spur = 1'b0;
  int            mrdy_low = 0;
  int            lat_cfg = 1;
  int            resp_due = -1;
  logic [DW-1:0] resp_word = '0;

  int            phase = 0;     // 0 free, 1 request on the bus, 2 awaiting read data
  int            m_owner = 0;   // 0 icache, 1 dcache
  int            m_streak = 0;
  bit            m_perr = 1'b0;
  logic [AW-1:0] m_addr = '0;

  int grants[$];
  int ic_resp_cyc = -1, ic_resp_cnt = 0, dc_resp_cnt = 0, mvalid_cnt = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_ic(input logic [AW-1:0] a);
    ic_pend = 1'b1;
    ic_a    = a;
  endtask

  task automatic new_dc(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m);
    dc_pend = 1'b1;
    dc_rw   = rw;
    dc_a    = a;
    dc_d    = d;
    dc_m    = m;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic step();
    bit mrdy, rv, acc, busy_in, wait_in;
    @(negedge clk);
    rst  = rst_v;
    mrdy = (mrdy_low > 0) ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    if (mrdy_low > 0) mrdy_low--;
    rv = (resp_due == 0) || spur;
    bus.ic_req_valid   = ic_pend;
    bus.ic_req_addr    = ic_a;
    bus.dc_req_valid   = dc_pend;
    bus.dc_req_rw      = dc_rw;
    bus.dc_req_addr    = dc_a;
    bus.dc_req_data    = dc_d;
    bus.dc_req_mask    = dc_m;
    bus.mem_req_ready  = mrdy;
    bus.mem_resp_valid = rv;
    bus.mem_resp_data  = (resp_due == 0) ? resp_word : rnd_word();
    #1;
    cyc++;

    busy_in = (phase == 1) && !rst_v;
    wait_in = (phase == 2) && !rst_v;
    acc     = busy_in && mrdy;
    chk("mem_req_valid", bus.mem_req_valid, busy_in);
    if (busy_in) begin
      if (m_owner == 1) begin
        chk("dc_rw",   bus.mem_req_rw, dc_rw);
        chk("dc_addr", bus.mem_req_addr, dc_a);
        chk("dc_data", bus.mem_req_data, dc_d);
        chk("dc_mask", bus.mem_req_mask, dc_rw ? dc_m : '0);
      end else begin
        chk("ic_rw",   bus.mem_req_rw, 1'b0);
        chk("ic_addr", bus.mem_req_addr, ic_a);
        chk("ic_mask", bus.mem_req_mask, '0);
      end
    end
    chk("ic_req_ready",  bus.ic_req_ready, acc && m_owner == 0);
    chk("dc_req_ready",  bus.dc_req_ready, acc && m_owner == 1);
    chk("ic_resp_valid", bus.ic_resp_valid, wait_in && rv && m_owner == 0);
    chk("dc_resp_valid", bus.dc_resp_valid, wait_in && rv && m_owner == 1);
    chk("ic_resp_data",  bus.ic_resp_data, bus.mem_resp_data);
    chk("dc_resp_data",  bus.dc_resp_data, bus.mem_resp_data);
    if (wait_in && rv)
      chk("read_data", (m_owner == 0) ? bus.ic_resp_data : bus.dc_resp_data, refm[m_addr[5:0]]);
    chk("protocol_err", bus.protocol_err, m_perr);

    if (bus.ic_req_ready) grants.push_back(0);
    if (bus.dc_req_ready) grants.push_back(1);
    if (bus.mem_req_valid) mvalid_cnt++;
    if (bus.ic_resp_valid) begin ic_resp_cnt++; ic_resp_cyc = cyc; end
    if (bus.dc_resp_valid) dc_resp_cnt++;

    // Memory behaves only on what actually appears on its port.
    if (resp_due >= 0) resp_due--;
    if (bus.mem_req_valid && mrdy) begin
      if (bus.mem_req_rw) begin
        memb[bus.mem_req_addr[5:0]] = merge(memb[bus.mem_req_addr[5:0]], bus.mem_req_data,
                                            bus.mem_req_mask);
      end else begin
        resp_word = memb[bus.mem_req_addr[5:0]];
        resp_due  = ((lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 3))) - 1;
      end
    end

    if (rst_v) begin
      phase = 0; m_streak = 0; m_perr = 1'b0; ic_pend = 1'b0; dc_pend = 1'b0;
    end else begin
      if (rv && phase != 2) m_perr = 1'b1;
      case (phase)
        0: if (ic_pend || dc_pend) begin
          if (dc_pend && !(ic_pend && m_streak == SMAX)) begin
            m_owner  = 1;
            m_addr   = dc_a;
            m_streak = ic_pend ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
          end else begin
            m_owner  = 0;
            m_addr   = ic_a;
            m_streak = 0;
          end
          phase = 1;
        end
        1: if (mrdy) begin
          if (m_owner == 1 && dc_rw) begin
            refm[dc_a[5:0]] = merge(refm[dc_a[5:0]], dc_d, dc_m);
            phase = 0;
          end else begin
            phase = 2;
          end
          if (m_owner == 1) dc_pend = 1'b0;
          else ic_pend = 1'b0;
        end
        2: if (rv) phase = 0;
        default: phase = 0;
      endcase
    end

    if (!ic_pend && (auto_ic || (rand_req && $urandom_range(0, 3) == 0)))
      new_ic(AW'($urandom_range(0, 63)));
    if (!dc_pend && (auto_dc || (rand_req && $urandom_range(0, 3) == 0)))
      new_dc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), rnd_word(), MW'($urandom));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int c0, base_ic, base_dc;
    int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    rst = 1'b1;
    bus.ic_req_valid = 1'b0; bus.ic_req_addr = '0;
    bus.dc_req_valid = 1'b0; bus.dc_req_rw = 1'b0; bus.dc_req_addr = '0;
    bus.dc_req_data = '0; bus.dc_req_mask = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    for (int i = 0; i < 64; i++) begin
      memb[i] = rnd_word();
      refm[i] = memb[i];
    end
    memb[16] = {4{32'hDEADBEEF}};
    refm[16] = {4{32'hDEADBEEF}};
    @(posedge clk);

    // Reset state
    rst_v = 1'b1; run(2);
    rst_v = 1'b0; run(1);

    // Lone icache read, memory latency 2
    lat_cfg = 2; c0 = cyc; base_dc = dc_resp_cnt;
    new_ic(AW'(28'h0000010));
    run(6);
    chk("ic_resp_cycle", ic_resp_cyc, c0 + 4);
    chk("ic_resp_count", ic_resp_cnt, 1);
    chk("ic_only_no_dc_resp", dc_resp_cnt, base_dc);

    // Simultaneous dcache write and icache read
    grants.delete(); base_dc = dc_resp_cnt;
    new_dc(1'b1, AW'(28'h20), rnd_word(), 16'h000F);
    new_ic(AW'($urandom_range(0, 63)));
    run(10);
    chk("both_grant_count", grants.size(), 2);
    if (grants.size() >= 2) begin
      chk("both_first_dc", grants[0], 1);
      chk("both_second_ic", grants[1], 0);
    end
    chk("write_no_resp", dc_resp_cnt, base_dc);

    // Continuous contention: dcache streak then forced icache
    grants.delete(); lat_cfg = 1;
    auto_ic = 1'b1; auto_dc = 1'b1;
    new_ic(AW'($urandom_range(0, 63)));
    new_dc(1'b1, AW'($urandom_range(0, 63)), rnd_word(), MW'($urandom));
    run(70);
    auto_ic = 1'b0; auto_dc = 1'b0;
    run(12);
    chk("streak_grant_count_ge10", grants.size() >= 10, 1'b1);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      chk($sformatf("streak_grant_%0d", i), grants[i], exp_order[i]);

    // Memory stalls five cycles in REQ
    grants.delete(); mvalid_cnt = 0; mrdy_low = 6;
    new_dc(1'b1, AW'($urandom_range(0, 63)), rnd_word(), MW'($urandom));
    run(10);
    chk("stall_valid_cycles", mvalid_cnt, 6);
    chk("stall_single_grant", grants.size(), 1);

    // Reset while waiting for read data, response arrives afterwards
    lat_cfg = 5; base_ic = ic_resp_cnt;
    new_ic(AW'($urandom_range(0, 63)));
    run(3);
    rst_v = 1'b1; run(2);
    rst_v = 1'b0; run(3);
    chk("abandoned_no_resp", ic_resp_cnt, base_ic);
    chk("abandoned_perr", bus.protocol_err, 1'b1);
    lat_cfg = 1; base_dc = dc_resp_cnt;
    new_dc(1'b0, AW'($urandom_range(0, 63)), '0, '0);
    run(6);
    chk("after_reset_read", dc_resp_cnt, base_dc + 1);

    // Spurious response in IDLE is sticky until reset
    rst_v = 1'b1; run(2);
    rst_v = 1'b0; run(1);
    spur = 1'b1; run(1);
    spur = 1'b0; run(4);
    chk("spurious_perr_sticky", bus.protocol_err, 1'b1);
    rst_v = 1'b1; run(1);
    rst_v = 1'b0; run(1);
    chk("perr_cleared", bus.protocol_err, 1'b0);

    // Randomized traffic
    rand_req = 1'b1; rand_rdy = 1'b1; lat_cfg = 0;
    run(600);
    rand_req = 1'b0;
    run(30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
